// File: rtl/fifo_bank_pkg.sv
// -----------------------------------------------------------------------------
// fifo_bank_pkg
// Shared types and width helpers for the multi-channel FIFO bank.
//   fifo_mode_e : output mode of a channel (registered read or fall-through)
//   addr_width  : address bits needed to index DEPTH entries
//   ptr_width   : address bits plus one wrap bit
//   cnt_width   : occupancy counter width, able to hold 0..DEPTH
//   mode_of     : maps the integer FWFT parameter onto fifo_mode_e
// -----------------------------------------------------------------------------
package fifo_bank_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic fifo_mode_e mode_of(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/fifo_bank_channel.sv
// -----------------------------------------------------------------------------
// fifo_bank_channel
// One independent FIFO channel: storage, wrap-bit pointers, occupancy count,
// status flags and sticky overflow/underflow error flags.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   wr_en/wr_data : write request and data
//   rd_en         : read request (pop in fall-through mode)
//   err_clear     : clears the sticky error flags
//   rd_data       : read data (registered, or head entry in fall-through mode)
//   rd_valid      : rd_data is valid
//   full/empty    : pointer-derived status
//   almost_full   : count >= AF_LEVEL
//   almost_empty  : count <= AE_LEVEL
//   count         : occupancy, 0..DEPTH
//   overflow      : sticky, a write was refused
//   underflow     : sticky, a read was refused
// -----------------------------------------------------------------------------
module fifo_bank_channel
    import fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    input  logic                          err_clear,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int         ADDR_W = addr_width(DEPTH);
    localparam int         PTR_W  = ptr_width(DEPTH);
    localparam int         CNT_W  = cnt_width(DEPTH);
    localparam fifo_mode_e MODE   = mode_of(FWFT);

    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              full_int;
    logic              empty_int;
    logic              wr_acc;
    logic              rd_acc;

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Same address with opposite wrap bits means the writer has lapped the reader.
    assign empty_int = (wr_ptr == rd_ptr);
    assign full_int  = (wr_addr == rd_addr) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    // A full channel may still take a write when a read frees a slot this cycle.
    assign rd_acc = rd_en & ~empty_int;
    assign wr_acc = wr_en & (~full_int | rd_acc);

    // NOTE: the storage array has no reset; clearing it would stop it mapping
    // onto distributed RAM, and the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                cnt <= cnt + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt <= cnt - 1'b1;
            end

            // A new error in the same cycle as err_clear keeps the flag set.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clear) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clear) begin
                underflow <= 1'b0;
            end
        end
    end

    // Status comes only from registered pointers and count.
    assign full         = full_int;
    assign empty        = empty_int;
    assign count        = cnt;
    assign almost_full  = (cnt >= AF_CNT);
    assign almost_empty = (cnt <= AE_CNT);

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head entry is shown continuously; forced to zero while empty so
            // unwritten storage never reaches the output.
            // NOTE: always_comb assigns a default first so no path can infer a latch.
            always_comb begin
                rd_data = '0;
                if (!empty_int) begin
                    rd_data = mem[rd_addr];
                end
            end
            assign rd_valid = ~empty_int;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // rd_valid pulses for the cycle after each accepted read; the data
            // register holds its last value between reads.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_addr];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_bank.sv
// -----------------------------------------------------------------------------
// fifo_bank
// CHANNELS independent FIFOs sharing one clock, used to skew and feed operands
// into the systolic array edges. Vectors are packed per channel: channel c
// uses bits [c*W +: W] of each multi-bit bus.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   wr_en, wr_data        : per-channel write request and data
//   rd_en                 : per-channel read request
//   err_clear             : clears every channel's sticky error flags
//   rd_data, rd_valid     : per-channel read data and valid
//   full, empty           : per-channel occupancy status
//   almost_full/_empty    : per-channel programmable-level status
//   count                 : per-channel occupancy, log2(DEPTH)+1 bits each
//   overflow, underflow   : per-channel sticky error flags
// -----------------------------------------------------------------------------
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [CHANNELS-1:0]                    wr_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0]         wr_data,
    input  logic [CHANNELS-1:0]                    rd_en,
    output logic [CHANNELS*DATA_WIDTH-1:0]         rd_data,
    output logic [CHANNELS-1:0]                    rd_valid,
    output logic [CHANNELS-1:0]                    full,
    output logic [CHANNELS-1:0]                    empty,
    output logic [CHANNELS-1:0]                    almost_full,
    output logic [CHANNELS-1:0]                    almost_empty,
    output logic [CHANNELS*cnt_width(DEPTH)-1:0]   count,
    output logic [CHANNELS-1:0]                    overflow,
    output logic [CHANNELS-1:0]                    underflow,
    input  logic                                   err_clear
);

    localparam int CNT_W = cnt_width(DEPTH);

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            fifo_bank_channel #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .FWFT       (FWFT),
                .AF_LEVEL   (AF_LEVEL),
                .AE_LEVEL   (AE_LEVEL)
            ) u_channel (
                .clk          (clk),
                .reset        (reset),
                .wr_en        (wr_en[c]),
                .wr_data      (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .rd_en        (rd_en[c]),
                .err_clear    (err_clear),
                .rd_data      (rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .rd_valid     (rd_valid[c]),
                .full         (full[c]),
                .empty        (empty[c]),
                .almost_full  (almost_full[c]),
                .almost_empty (almost_empty[c]),
                .count        (count[c*CNT_W +: CNT_W]),
                .overflow     (overflow[c]),
                .underflow    (underflow[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fifo_bank.sv
// -----------------------------------------------------------------------------
// tb_fifo_bank
// Bench for fifo_bank. A standard-mode instance (dut) is checked through a
// per-channel scoreboard: each issued read pushes its expected data, and a
// monitor pops and compares whenever rd_valid is seen. A fall-through instance
// (dut_f) covers the FWFT behaviour with direct checks.
// -----------------------------------------------------------------------------
module tb_fifo_bank;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int CH = 4;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            err_clear;

    logic [CH-1:0]    wr_en, rd_en;
    logic [CH*DW-1:0] wr_data;
    logic [CH*DW-1:0] rd_data;
    logic [CH-1:0]    rd_valid, full, empty, almost_full, almost_empty;
    logic [CH*CW-1:0] count;
    logic [CH-1:0]    overflow, underflow;

    logic [CH-1:0]    wr_en_f, rd_en_f;
    logic [CH*DW-1:0] wr_data_f;
    logic [CH*DW-1:0] rd_data_f;
    logic [CH-1:0]    rd_valid_f, full_f, empty_f, almost_full_f, almost_empty_f;
    logic [CH*CW-1:0] count_f;
    logic [CH-1:0]    overflow_f, underflow_f;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb [CH][$];

    always #5 clk = ~clk;

    fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DP), .CHANNELS(CH), .FWFT(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clear    (err_clear)
    );

    fifo_bank #(.DATA_WIDTH(DW), .DEPTH(DP), .CHANNELS(CH), .FWFT(1)) dut_f (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en_f),
        .wr_data      (wr_data_f),
        .rd_en        (rd_en_f),
        .rd_data      (rd_data_f),
        .rd_valid     (rd_valid_f),
        .full         (full_f),
        .empty        (empty_f),
        .almost_full  (almost_full_f),
        .almost_empty (almost_empty_f),
        .count        (count_f),
        .overflow     (overflow_f),
        .underflow    (underflow_f),
        .err_clear    (err_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the standard-mode instance.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rd_valid[c] === 1'b1) begin
                if (sb[c].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_ch%0d: got rd_valid with data 0x%0h, expected no read", c, rd_data[c*DW +: DW]);
                end else begin
                    check($sformatf("sb_data_ch%0d", c), 32'(rd_data[c*DW +: DW]), 32'(sb[c].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        err_clear = 1'b0;
        wr_en     = '0;
        rd_en     = '0;
        wr_data   = '0;
        wr_en_f   = '0;
        rd_en_f   = '0;
        wr_data_f = '0;
        tick();
        tick();
        reset = 1'b0;

        // ---- Reset state ----
        check("rst_count",    32'(count),    32'h0);
        check("rst_empty",    32'(empty),    32'hF);
        check("rst_ae",       32'(almost_empty), 32'hF);
        check("rst_full",     32'(full),     32'h0);
        check("rst_af",       32'(almost_full), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_rd_data",  rd_data,       32'h0);
        check("rst_ovf",      32'(overflow), 32'h0);
        check("rst_udf",      32'(underflow), 32'h0);
        check("rst_f_valid",  32'(rd_valid_f), 32'h0);
        check("rst_f_data",   rd_data_f,     32'h0);

        // ---- Fill ch0 with 0x01..0x10 ----
        for (int i = 1; i <= DP; i++) begin
            wr_en[0]          = 1'b1;
            wr_data[0*DW +: DW] = DW'(i);
            tick();
            check($sformatf("fill_count_%0d", i), 32'(count[0*CW +: CW]), 32'(i));
            check($sformatf("fill_af_%0d", i),    32'(almost_full[0]), 32'(i >= 14));
            check($sformatf("fill_full_%0d", i),  32'(full[0]),        32'(i == 16));
            check($sformatf("fill_ae_%0d", i),    32'(almost_empty[0]), 32'(i <= 2));
        end
        wr_en = '0;
        check("fill_other_empty", 32'(empty[3:1]), 32'h7);
        check("fill_other_full",  32'(full[3:1]),  32'h0);

        // ---- Overflow and sticky clear ----
        wr_en[0]            = 1'b1;
        wr_data[0*DW +: DW] = 8'hAA;
        tick();
        wr_en = '0;
        check("ovf_set",   32'(overflow[0]), 32'h1);
        check("ovf_count", 32'(count[0*CW +: CW]), 32'd16);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ovf_cleared", 32'(overflow[0]), 32'h0);
        err_clear           = 1'b1;
        wr_en[0]            = 1'b1;
        wr_data[0*DW +: DW] = 8'hBB;
        tick();
        err_clear = 1'b0;
        wr_en     = '0;
        check("ovf_set_wins", 32'(overflow[0]), 32'h1);
        check("ovf_count2",   32'(count[0*CW +: CW]), 32'd16);

        // ---- Full channel: simultaneous write and read, then drain ----
        wr_en[0]            = 1'b1;
        wr_data[0*DW +: DW] = 8'h55;
        rd_en[0]            = 1'b1;
        sb[0].push_back(8'h01);
        tick();
        wr_en = '0;
        rd_en = '0;
        check("wr_rd_full_count", 32'(count[0*CW +: CW]), 32'd16);
        check("wr_rd_full_flag",  32'(full[0]), 32'h1);
        for (int i = 2; i <= DP + 1; i++) begin
            rd_en[0] = 1'b1;
            sb[0].push_back((i <= DP) ? DW'(i) : 8'h55);
            tick();
        end
        rd_en = '0;
        tick();
        check("drain_empty", 32'(empty[0]), 32'h1);
        check("drain_count", 32'(count[0*CW +: CW]), 32'h0);
        check("drain_udf",   32'(underflow[0]), 32'h0);

        // ---- FWFT: write into empty ch2, visible next cycle, then pop ----
        wr_en_f[2]              = 1'b1;
        wr_data_f[2*DW +: DW]   = 8'h3C;
        tick();
        wr_en_f = '0;
        check("fwft_valid", 32'(rd_valid_f[2]), 32'h1);
        check("fwft_data",  32'(rd_data_f[2*DW +: DW]), 32'h3C);
        check("fwft_count", 32'(count_f[2*CW +: CW]), 32'h1);
        tick();
        check("fwft_hold",  32'(rd_data_f[2*DW +: DW]), 32'h3C);
        rd_en_f[2] = 1'b1;
        tick();
        rd_en_f = '0;
        check("fwft_pop_empty", 32'(empty_f[2]), 32'h1);
        check("fwft_pop_valid", 32'(rd_valid_f[2]), 32'h0);

        // ---- Standard: write+read on empty ch1 ----
        wr_en[1]            = 1'b1;
        wr_data[1*DW +: DW] = 8'h11;
        rd_en[1]            = 1'b1;
        tick();
        wr_en = '0;
        rd_en = '0;
        check("udf_set",      32'(underflow[1]), 32'h1);
        check("udf_count",    32'(count[1*CW +: CW]), 32'h1);
        check("udf_no_valid", 32'(rd_valid[1]), 32'h0);
        rd_en[1] = 1'b1;
        sb[1].push_back(8'h11);
        tick();
        rd_en = '0;
        check("std_valid", 32'(rd_valid[1]), 32'h1);
        check("std_data",  32'(rd_data[1*DW +: DW]), 32'h11);
        tick();
        check("std_valid_pulse", 32'(rd_valid[1]), 32'h0);
        check("std_data_hold",   32'(rd_data[1*DW +: DW]), 32'h11);

        // ---- Reset with ch3 holding 5 entries ----
        for (int i = 0; i < 5; i++) begin
            wr_en[3]            = 1'b1;
            wr_data[3*DW +: DW] = 8'h30 + DW'(i);
            tick();
        end
        wr_en = '0;
        check("pre_rst_count3", 32'(count[3*CW +: CW]), 32'd5);
        check("pre_rst_ae3",    32'(almost_empty[3]), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count3", 32'(count[3*CW +: CW]), 32'h0);
        check("mid_rst_empty3", 32'(empty[3]), 32'h1);
        check("mid_rst_ae3",    32'(almost_empty[3]), 32'h1);
        check("mid_rst_valid",  32'(rd_valid), 32'h0);
        check("mid_rst_ovf",    32'(overflow), 32'h0);
        check("mid_rst_udf",    32'(underflow), 32'h0);
        tick();

        for (int c = 0; c < CH; c++) begin
            check($sformatf("sb_drained_ch%0d", c), 32'(sb[c].size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
